song_sequencer: RTL and testbench

- Autoplay controller for the piano buzzer datapath.
- Walks a song stored in an external synchronous ROM and presents one note at a time as note/pitch/stop to the buzzer.
- Times each note in tick units and inserts a fixed silent gap between notes for articulation.
- Supports start, pause and abort from the top-level mode controller.

---
 rtl/song_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: autoplay controller that walks a song ROM and drives the buzzer note/pitch/stop.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_start     one-cycle pulse, starts the song at index 0 (IDLE only)
//   i_pause     level, freezes playback and forces stop while high
//   i_abort     one-cycle pulse, returns to IDLE with reset outputs
//   o_rom_addr  song ROM address (synchronous ROM, 1-cycle latency)
//   i_rom_data  [6:0] note, [9:7] pitch one-hot, [17:10] duration in units
//   o_note      note to buzzer
//   o_pitch     pitch to buzzer
//   o_stop      stop to buzzer
//   o_busy      high in any state other than IDLE
//   o_done      one-cycle pulse at song end
//   o_idx       index of the current song entry
//
// Optional feature: define SONG_REPEAT_EN to loop the song forever until abort.
module song_sequencer #(
    parameter int TICK_DIV   = 100000,
    parameter int UNIT_TICKS = 10,
    parameter int GAP_TICKS  = 20,
    parameter int ADDR_W     = 6,
    parameter int SONG_LEN   = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [17:0]       i_rom_data,
    output logic [6:0]        o_note,
    output logic [2:0]        o_pitch,
    output logic              o_stop,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_idx
);
    localparam int TW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SMAX = UNIT_TICKS > GAP_TICKS ? UNIT_TICKS : GAP_TICKS;
    localparam int SW   = SMAX > 1 ? $clog2(SMAX) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     UNIT_LAST = SW'(UNIT_TICKS - 1);
    localparam logic [SW-1:0]     GAP_LAST  = SW'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);
    localparam logic [2:0]        PITCH_DEF = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_FINISH} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [TW-1:0]     r_tick;
    logic [SW-1:0]     r_sub;
    logic [7:0]        r_units;
    logic [6:0]        r_note;
    logic [2:0]        r_pitch;
    logic              r_stop;
    logic              r_busy;
    logic              r_done;

    logic       w_timed;
    logic       w_run;
    logic       w_tick_end;
    logic [7:0] w_dur;
    logic [2:0] w_pitch_in;
    logic       w_pitch_ok;

    assign w_timed    = (r_state == S_PLAY) || (r_state == S_GAP);
    assign w_run      = w_timed && !i_pause;
    assign w_tick_end = r_tick == TICK_LAST;
    assign w_dur      = i_rom_data[17:10];
    assign w_pitch_in = i_rom_data[9:7];
    assign w_pitch_ok = (w_pitch_in == 3'b001) || (w_pitch_in == 3'b010) || (w_pitch_in == 3'b100);

    assign o_rom_addr = r_idx;
    assign o_idx      = r_idx;
    assign o_note     = r_note;
    assign o_pitch    = r_pitch;
    // Pause must silence the buzzer in the same cycle it is raised, so it bypasses the stop register.
    assign o_stop     = r_stop | (i_pause & w_timed);
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tick  <= '0;
            r_sub   <= '0;
            r_units <= '0;
            r_note  <= '0;
            r_pitch <= PITCH_DEF;
            r_stop  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tick  <= '0;
            r_sub   <= '0;
            r_units <= '0;
            r_note  <= '0;
            r_pitch <= PITCH_DEF;
            r_stop  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_run)
                r_tick <= w_tick_end ? '0 : r_tick + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_FETCH;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    if (w_dur == 8'd0) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_note  <= '0;
                        r_stop  <= 1'b1;
                    end else begin
                        r_state <= S_PLAY;
                        r_note  <= i_rom_data[6:0];
                        r_pitch <= w_pitch_ok ? w_pitch_in : PITCH_DEF;
                        r_units <= w_dur;
                        r_tick  <= '0;
                        r_sub   <= '0;
                        r_stop  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // Nested tick/unit/duration counters give dur*UNIT_TICKS*TICK_DIV cycles without a multiplier.
                    if (w_run && w_tick_end) begin
                        if (r_sub == UNIT_LAST) begin
                            r_sub <= '0;
                            if (r_units == 8'd1) begin
                                r_state <= S_GAP;
                                r_note  <= '0;
                            end else begin
                                r_units <= r_units - 8'd1;
                            end
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_run && w_tick_end) begin
                        if (r_sub == GAP_LAST) begin
                            r_sub <= '0;
                            if (r_idx == IDX_LAST) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                                r_stop  <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                                r_idx   <= r_idx + 1'b1;
                            end
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_idx <= '0;
`ifdef SONG_REPEAT_EN
                    r_state <= S_FETCH;
`else
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed self-checking bench for song_sequencer with a behavioural synchronous ROM.
module tb_song_sequencer;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [17:0]       rom_data = '0;
    logic [6:0]        note;
    logic [2:0]        pitch;
    logic              stop;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] idx;

    logic [17:0] rom [0:7];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int max_addr = 0;

    song_sequencer #(
        .TICK_DIV(4), .UNIT_TICKS(2), .GAP_TICKS(1), .ADDR_W(ADDR_W), .SONG_LEN(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_abort(abort),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_note(note), .o_pitch(pitch),
        .o_stop(stop), .o_busy(busy), .o_done(done), .o_idx(idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
            cyc++;
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        end
    endtask

    task automatic begin_song(input logic with_pause);
        start = 1'b1;
        pause = with_pause;
        cyc = 0;
        adv_to(1);
        start = 1'b0;
    endtask

    // f is the FINISH cycle; n0 is the note of ROM[0] expected to replay when looping.
    task automatic end_song(input int f, input logic [6:0] n0);
        adv_to(f - 1);
        chk("done_before", {31'd0, done}, 32'd0);
        adv_to(f);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("finish_stop", {31'd0, stop}, 32'd1);
        adv_to(f + 1);
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("end_addr", {29'd0, rom_addr}, 32'd0);
`ifdef SONG_REPEAT_EN
        chk("repeat_busy", {31'd0, busy}, 32'd1);
        adv_to(f + 3);
        chk("repeat_note", {25'd0, note}, {25'd0, n0});
        abort = 1'b1;
        adv_to(f + 4);
        abort = 1'b0;
`endif
        chk("end_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = {8'd5, 3'b001, 7'h7f};
        rom[0] = {8'd3, 3'b010, 7'b0000001};
        rom[1] = 18'd0;

        // Reset values
        adv_to(2);
        chk("rst_note", {25'd0, note}, 32'd0);
        chk("rst_pitch", {29'd0, pitch}, 32'd2);
        chk("rst_stop", {31'd0, stop}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_idx", {29'd0, idx}, 32'd0);
        chk("rst_addr", {29'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        adv_to(4);

        // Case 1: single note then end marker
        begin_song(1'b0);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        adv_to(2);
        chk("c1_load_stop", {31'd0, stop}, 32'd1);
        for (int c = 3; c <= 26; c++) begin
            adv_to(c);
            chk("c1_play", {23'd0, note, pitch, 1'b0, stop}, {23'd0, 7'd1, 3'b010, 2'b00});
        end
        for (int c = 27; c <= 30; c++) begin
            adv_to(c);
            chk("c1_gap", {24'd0, note, stop}, 32'd0);
        end
        adv_to(31);
        chk("c1_fetch_addr", {29'd0, rom_addr}, 32'd1);
        chk("c1_fetch_idx", {29'd0, idx}, 32'd1);
        end_song(33, 7'd1);

        // Case 2: pause cycles 10..19 stretches the note to cycle 36
        adv_to(cyc + 2);
        begin_song(1'b0);
        adv_to(9);
        chk("c2_prepause", {31'd0, stop}, 32'd0);
        adv_to(10);
        pause = 1'b1;
        #1;
        chk("c2_pause_stop", {31'd0, stop}, 32'd1);
        for (int c = 11; c <= 19; c++) begin
            adv_to(c);
            chk("c2_paused", {24'd0, note, stop}, {24'd0, 7'd1, 1'b1});
        end
        adv_to(20);
        pause = 1'b0;
        #1;
        chk("c2_resume", {24'd0, note, stop}, {24'd0, 7'd1, 1'b0});
        adv_to(36);
        chk("c2_last_play", {24'd0, note, stop}, {24'd0, 7'd1, 1'b0});
        adv_to(37);
        chk("c2_gap", {24'd0, note, stop}, 32'd0);
        end_song(43, 7'd1);

        // Case 3: abort mid-GAP with a coincident start that must be ignored
        rom[0] = {8'd3, 3'b100, 7'b0000100};
        adv_to(cyc + 2);
        begin_song(1'b0);
        adv_to(3);
        chk("c3_play", {25'd0, note}, 32'd4);
        chk("c3_pitch", {29'd0, pitch}, 32'd4);
        adv_to(28);
        chk("c3_gap_pitch", {29'd0, pitch}, 32'd4);
        abort = 1'b1;
        start = 1'b1;
        adv_to(29);
        abort = 1'b0;
        start = 1'b0;
        chk("c3_abort_out", {23'd0, note, pitch, stop, busy, done}, {23'd0, 7'd0, 3'b010, 1'b1, 1'b0, 1'b0});
        chk("c3_abort_idx", {29'd0, idx}, 32'd0);
        adv_to(32);
        chk("c3_no_done", {30'd0, busy, done}, 32'd0);

        // Cases 4/5: four dur=1 entries, no end marker, two with illegal pitch
        rom[0] = {8'd1, 3'b000, 7'b0000001};
        rom[1] = {8'd1, 3'b011, 7'b0000010};
        rom[2] = {8'd1, 3'b001, 7'b0000000};
        rom[3] = {8'd1, 3'b100, 7'b1000000};
        max_addr = 0;
        adv_to(cyc + 2);
        begin_song(1'b0);
        adv_to(3);
        chk("c5_pitch000", {22'd0, idx, note, pitch}, {22'd0, 3'd0, 7'd1, 3'b010});
        adv_to(10);
        chk("c4_play0_end", {24'd0, note, stop}, {24'd0, 7'd1, 1'b0});
        adv_to(11);
        chk("c4_gap0", {25'd0, note}, 32'd0);
        adv_to(17);
        chk("c5_pitch011", {22'd0, idx, note, pitch}, {22'd0, 3'd1, 7'd2, 3'b010});
        adv_to(31);
        chk("c4_rest", {21'd0, idx, note, pitch, stop}, {21'd0, 3'd2, 7'd0, 3'b001, 1'b0});
        adv_to(45);
        chk("c4_idx3", {22'd0, idx, note, pitch}, {22'd0, 3'd3, 7'h40, 3'b100});
        adv_to(56);
        chk("c4_gap3", {21'd0, idx, note, pitch, stop}, {21'd0, 3'd3, 7'd0, 3'b100, 1'b0});
        end_song(57, 7'd1);
        chk("c4_max_addr", max_addr, 32'd3);

        // Case 7: start with pause held, then async reset mid-PLAY
        adv_to(cyc + 2);
        begin_song(1'b1);
        adv_to(3);
        chk("c7_start_paused", {23'd0, note, 1'b0, stop, busy}, {23'd0, 7'd1, 1'b0, 1'b1, 1'b1});
        adv_to(5);
        pause = 1'b0;
        #1;
        chk("c7_unpaused", {31'd0, stop}, 32'd0);
        adv_to(9);
        rst_n = 1'b0;
        #1;
        chk("c7_async_rst", {23'd0, note, pitch, stop, busy, done}, {23'd0, 7'd0, 3'b010, 1'b1, 1'b0, 1'b0});
        chk("c7_async_idx", {29'd0, idx}, 32'd0);
        adv_to(10);
        rst_n = 1'b1;
        adv_to(12);
        chk("c7_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
